// File: rtl/ms_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : ms_rd_slave
// Brief    : Read-side responder for the ms_if register slave. Four-entry
//            register bank with a valid/ready read channel and a buffered
//            response FIFO that absorbs master backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module ms_rd_slave #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ar_valid,
    input  logic [1:0]        ar_addr,
    output logic              ar_ready,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_addr,
    input  logic              r_ready,
    output logic [7:0]        rd_cnt
);

    localparam int                 c_SLOTS = 4;
    localparam logic [2:0]         c_DEPTH = 3'(DEPTH);
    localparam logic [1:0]         c_LAST  = 2'(DEPTH - 1);

    logic [DATA_W-1:0] r_bank      [c_SLOTS];
    // Storage is sized for the largest legal DEPTH; slots at or beyond DEPTH
    // are never written and stay at their reset value.
    logic [DATA_W-1:0] r_fifo_data [c_SLOTS];
    logic [1:0]        r_fifo_addr [c_SLOTS];
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic [2:0]        r_count;
    logic [7:0]        r_rd_cnt;

    logic              w_push;
    logic              w_pop;

    function automatic logic [1:0] f_next(input logic [1:0] ptr);
        return (ptr == c_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

    assign ar_ready = (r_count < c_DEPTH) && !rst;
    assign r_valid  = (r_count != 3'd0);
    assign r_data   = r_fifo_data[r_rd_ptr];
    assign r_addr   = r_fifo_addr[r_rd_ptr];
    assign rd_cnt   = r_rd_cnt;

    assign w_push   = ar_valid && ar_ready;
    assign w_pop    = r_valid && r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_SLOTS; i++) begin
                r_bank[i]      <= '0;
                r_fifo_data[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (wr_en) begin
                r_bank[wr_addr] <= wr_data;
            end
            // Bank read sees the pre-edge contents, so a same-edge write to
            // the requested address is not forwarded into the response.
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= r_bank[ar_addr];
                r_fifo_addr[r_wr_ptr] <= ar_addr;
                r_wr_ptr              <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
                r_rd_cnt <= r_rd_cnt + 8'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ms_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ms_rd_slave
// Brief    : Directed self-checking bench for ms_rd_slave (DATA_W=8, DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ms_rd_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       ar_valid = 1'b0;
    logic [1:0] ar_addr = '0;
    logic       ar_ready;
    logic       r_valid;
    logic [7:0] r_data;
    logic [1:0] r_addr;
    logic       r_ready = 1'b0;
    logic [7:0] rd_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    ms_rd_slave #(.DATA_W(8), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ar_valid (ar_valid),
        .ar_addr  (ar_addr),
        .ar_ready (ar_ready),
        .r_valid  (r_valid),
        .r_data   (r_data),
        .r_addr   (r_addr),
        .r_ready  (r_ready),
        .rd_cnt   (rd_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            n_vec++;
            if (ar_ready !== 1'b0 || r_valid !== 1'b0 || rd_cnt !== 8'd0) begin
                n_err++;
                $display("FAIL reset_hold: ar_ready=%b r_valid=%b rd_cnt=%0d, need 0/0/0",
                         ar_ready, r_valid, rd_cnt);
            end
        end
        rst = 1'b0;
        next_cycle();
        n_vec++;
        if (ar_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: ar_ready=%b, need 1", ar_ready);
        end
        r_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                n_vec++;
                if (r_valid !== 1'b1 || r_data !== 8'h00 || r_addr !== 2'(i - 1)) begin
                    n_err++;
                    $display("FAIL reset_read%0d: v=%b d=%h a=%0d, need 1/00/%0d",
                             i - 1, r_valid, r_data, r_addr, i - 1);
                end
            end
            ar_valid = (i < 4);
            ar_addr  = 2'(i);
            next_cycle();
        end
        exp_cnt += 4;
        n_vec++;
        if (r_valid !== 1'b0 || rd_cnt !== 8'(exp_cnt)) begin
            n_err++;
            $display("FAIL reset_read_cnt: v=%b rd_cnt=%0d, need 0/%0d", r_valid, rd_cnt, exp_cnt);
        end
    endtask

    task automatic test_write_stream();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_addr = 2'(i);
            wr_data = vals[i];
            next_cycle();
        end
        wr_en   = 1'b0;
        r_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                n_vec++;
                if (r_valid !== 1'b1 || r_data !== vals[i - 1] || r_addr !== 2'(i - 1)) begin
                    n_err++;
                    $display("FAIL stream_read%0d: v=%b d=%h a=%0d, need 1/%h/%0d",
                             i - 1, r_valid, r_data, r_addr, vals[i - 1], i - 1);
                end
            end
            ar_valid = (i < 4);
            ar_addr  = 2'(i);
            next_cycle();
        end
        exp_cnt += 4;
        n_vec++;
        if (r_valid !== 1'b0 || rd_cnt !== 8'(exp_cnt)) begin
            n_err++;
            $display("FAIL stream_cnt: v=%b rd_cnt=%0d, need 0/%0d", r_valid, rd_cnt, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        r_ready  = 1'b0;
        ar_valid = 1'b1;
        ar_addr  = 2'd3;
        next_cycle();
        ar_addr = 2'd2;
        n_vec++;
        if (r_valid !== 1'b1 || r_data !== 8'h44 || ar_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_first: v=%b d=%h rdy=%b, need 1/44/1", r_valid, r_data, ar_ready);
        end
        next_cycle();
        ar_addr = 2'd1;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (ar_ready !== 1'b0 || r_data !== 8'h44 || r_addr !== 2'd3) begin
                n_err++;
                $display("FAIL bp_full%0d: rdy=%b d=%h a=%0d, need 0/44/3", i, ar_ready, r_data, r_addr);
            end
            if (i == 0) next_cycle();
        end
        r_ready = 1'b1;
        next_cycle();
        n_vec++;
        if (r_valid !== 1'b1 || r_data !== 8'h33 || r_addr !== 2'd2 || ar_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second: v=%b d=%h a=%0d rdy=%b, need 1/33/2/1",
                     r_valid, r_data, r_addr, ar_ready);
        end
        next_cycle();
        ar_valid = 1'b0;
        n_vec++;
        if (r_valid !== 1'b1 || r_data !== 8'h22 || r_addr !== 2'd1) begin
            n_err++;
            $display("FAIL bp_third: v=%b d=%h a=%0d, need 1/22/1", r_valid, r_data, r_addr);
        end
        next_cycle();
        exp_cnt += 3;
        n_vec++;
        if (r_valid !== 1'b0 || rd_cnt !== 8'(exp_cnt)) begin
            n_err++;
            $display("FAIL bp_cnt: v=%b rd_cnt=%0d, need 0/%0d", r_valid, rd_cnt, exp_cnt);
        end
    endtask

    task automatic test_same_edge_raw();
        r_ready  = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 2'd2;
        wr_data  = 8'hA5;
        ar_valid = 1'b1;
        ar_addr  = 2'd2;
        next_cycle();
        wr_en = 1'b0;
        n_vec++;
        if (r_valid !== 1'b1 || r_data !== 8'h33 || r_addr !== 2'd2) begin
            n_err++;
            $display("FAIL raw_old: v=%b d=%h a=%0d, need 1/33/2", r_valid, r_data, r_addr);
        end
        next_cycle();
        ar_valid = 1'b0;
        n_vec++;
        if (r_valid !== 1'b1 || r_data !== 8'hA5 || r_addr !== 2'd2) begin
            n_err++;
            $display("FAIL raw_new: v=%b d=%h a=%0d, need 1/a5/2", r_valid, r_data, r_addr);
        end
        next_cycle();
        exp_cnt += 2;
        n_vec++;
        if (r_valid !== 1'b0 || rd_cnt !== 8'(exp_cnt)) begin
            n_err++;
            $display("FAIL raw_cnt: v=%b rd_cnt=%0d, need 0/%0d", r_valid, rd_cnt, exp_cnt);
        end
    endtask

    task automatic test_push_pop_full();
        // bank: 11 22 A5 44
        r_ready  = 1'b0;
        ar_valid = 1'b1;
        ar_addr  = 2'd0;
        next_cycle();
        ar_addr = 2'd1;
        next_cycle();
        n_vec++;
        if (ar_ready !== 1'b0 || r_data !== 8'h11) begin
            n_err++;
            $display("FAIL pp_full: rdy=%b d=%h, need 0/11", ar_ready, r_data);
        end
        r_ready = 1'b1;
        ar_addr = 2'd3;
        next_cycle();
        n_vec++;
        if (r_data !== 8'h22 || r_addr !== 2'd1 || ar_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pp_pop1: d=%h a=%0d rdy=%b, need 22/1/1", r_data, r_addr, ar_ready);
        end
        next_cycle();
        ar_addr = 2'd2;
        n_vec++;
        if (r_valid !== 1'b1 || r_data !== 8'h44 || r_addr !== 2'd3 || ar_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pp_push_pop: v=%b d=%h a=%0d rdy=%b, need 1/44/3/1",
                     r_valid, r_data, r_addr, ar_ready);
        end
        next_cycle();
        ar_valid = 1'b0;
        n_vec++;
        if (r_valid !== 1'b1 || r_data !== 8'hA5 || r_addr !== 2'd2) begin
            n_err++;
            $display("FAIL pp_last: v=%b d=%h a=%0d, need 1/a5/2", r_valid, r_data, r_addr);
        end
        next_cycle();
        exp_cnt += 4;
        n_vec++;
        if (r_valid !== 1'b0 || rd_cnt !== 8'(exp_cnt)) begin
            n_err++;
            $display("FAIL pp_cnt: v=%b rd_cnt=%0d, need 0/%0d", r_valid, rd_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_wrap();
        r_ready  = 1'b0;
        ar_valid = 1'b1;
        ar_addr  = 2'd0;
        next_cycle();
        ar_addr = 2'd1;
        next_cycle();
        rst     = 1'b1;
        ar_addr = 2'd2;
        next_cycle();
        n_vec++;
        if (r_valid !== 1'b0 || rd_cnt !== 8'd0 || r_data !== 8'h00 || ar_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: v=%b cnt=%0d d=%h rdy=%b, need 0/0/00/0",
                     r_valid, rd_cnt, r_data, ar_ready);
        end
        rst      = 1'b0;
        ar_valid = 1'b0;
        next_cycle();
        n_vec++;
        if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_release: v=%b rdy=%b, need 0/1", r_valid, ar_ready);
        end
        r_ready = 1'b1;
        for (int i = 0; i <= 257; i++) begin
            ar_valid = (i < 257);
            ar_addr  = 2'(i);
            next_cycle();
        end
        n_vec++;
        if (r_valid !== 1'b0 || rd_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL wrap_cnt: v=%b rd_cnt=%0d, need 0/1", r_valid, rd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_stream();
        test_backpressure();
        test_same_edge_raw();
        test_push_pop_full();
        test_reset_mid_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
